// File: rtl/sseg_signed_scan.sv
// Signed binary to multiplexed 7-segment driver.
// A load strobe captures a two's-complement word. A sequential double-dabble
// engine converts its magnitude to BCD. The result then drives N_DIG
// common-anode digits: the leftmost digit shows the sign and the rest show the
// decimal magnitude.
module sseg_signed_scan #(
    parameter int DATA_W      = 9,
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        SSeg,
    output logic [N_DIG-1:0]  an
);

    localparam int BCD_W  = (N_DIG - 1) * 4;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = $clog2(N_DIG);
    localparam int STEP_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mag;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic              ovf_tmp;
    logic              sign_tmp;
    logic [STEP_W-1:0] step;

    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_sign;
    logic              disp_valid;

    logic [CNT_W-1:0]  refresh_cnt;
    logic [IDX_W-1:0]  idx;
    logic [6:0]        glyph_sel;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 7'h40;
            4'd1:    digit_glyph = 7'h79;
            4'd2:    digit_glyph = 7'h24;
            4'd3:    digit_glyph = 7'h30;
            4'd4:    digit_glyph = 7'h19;
            4'd5:    digit_glyph = 7'h12;
            4'd6:    digit_glyph = 7'h02;
            4'd7:    digit_glyph = 7'h78;
            4'd8:    digit_glyph = 7'h00;
            4'd9:    digit_glyph = 7'h10;
            default: digit_glyph = 7'h7F;
        endcase
    endfunction

    // State register for the load/convert/commit sequence
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; CONV lasts exactly one cycle per input bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (step == STEP_W'(DATA_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < N_DIG - 1; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and the committed display registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag        <= '0;
            bcd        <= '0;
            ovf_tmp    <= 1'b0;
            sign_tmp   <= 1'b0;
            step       <= '0;
            disp_bcd   <= '0;
            disp_sign  <= 1'b0;
            disp_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sign_tmp <= value[DATA_W-1];
                        mag      <= value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
                        bcd      <= '0;
                        ovf_tmp  <= 1'b0;
                        step     <= '0;
                    end
                end
                CONV: begin
                    bcd  <= {bcd_adj[BCD_W-2:0], mag[DATA_W-1]};
                    mag  <= {mag[DATA_W-2:0], 1'b0};
                    step <= step + STEP_W'(1);
                    if (bcd_adj[BCD_W-1]) ovf_tmp <= 1'b1;
                end
                COMMIT: begin
                    disp_bcd   <= bcd;
                    disp_sign  <= sign_tmp;
                    ovf        <= ovf_tmp;
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Glyph for the digit currently being scanned
    always_comb begin
        logic [BCD_W-1:0] shifted;
        logic [6:0]       g;
        glyph_sel = 7'h7F;
        shifted   = '0;
        g         = 7'h7F;
        for (int i = 0; i < N_DIG; i++) begin
            shifted = disp_bcd >> (4 * i);
            if (!disp_valid)
                g = 7'h7F;
            else if (i == N_DIG - 1)
                g = (disp_sign && !ovf) ? 7'h3F : 7'h7F;
            else if (ovf)
                g = 7'h06;
            else if (BLANK_LZ != 0 && i != 0 && shifted == '0)
                g = 7'h7F;
            else
                g = digit_glyph(shifted[3:0]);
            if (idx == IDX_W'(i)) glyph_sel = g;
        end
    end

    // Free-running scan: each digit is held for REFRESH_DIV cycles, with an/SSeg registered together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an          <= '1;
            SSeg        <= 7'h7F;
        end else begin
            an   <= ~(N_DIG'(1) << idx);
            SSeg <= glyph_sel;
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                idx         <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sseg_signed_scan.sv
// Self-checking bench for sseg_signed_scan.
// It uses two instances: 9-bit with leading-zero blanking, and 12-bit showing
// all digits.
module tb_sseg_signed_scan;

    localparam int REFRESH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  value_a;
    logic        load_a;
    logic        busy_a, ovf_a;
    logic [6:0]  sseg_a;
    logic [3:0]  an_a;
    logic [11:0] value_b;
    logic        load_b;
    logic        busy_b, ovf_b;
    logic [6:0]  sseg_b;
    logic [3:0]  an_b;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          sel;
        int          val;
        logic [27:0] glyphs;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sseg_signed_scan #(.DATA_W(9), .N_DIG(4), .REFRESH_DIV(REFRESH), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .value(value_a), .load(load_a),
        .busy(busy_a), .ovf(ovf_a), .SSeg(sseg_a), .an(an_a)
    );

    sseg_signed_scan #(.DATA_W(12), .N_DIG(4), .REFRESH_DIV(REFRESH), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value_b), .load(load_b),
        .busy(busy_b), .ovf(ovf_b), .SSeg(sseg_b), .an(an_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf_a : ovf_b;
    endfunction

    function automatic logic [3:0] get_an(input int sel);
        return (sel == 0) ? an_a : an_b;
    endfunction

    function automatic logic [6:0] get_seg(input int sel);
        return (sel == 0) ? sseg_a : sseg_b;
    endfunction

    // Decimal digit to active-low glyph
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit model_ovf(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return m > 999;
    endfunction

    // Reference: what the four digits should read for a committed value
    function automatic logic [27:0] model_glyphs(input int v, input bit blank_lz);
        logic [27:0] r;
        int m, p;
        bit ov;
        m  = (v < 0) ? -v : v;
        ov = model_ovf(v);
        r[27:21] = (v < 0 && !ov) ? 7'h3F : 7'h7F;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            if (ov)                            r[7*i +: 7] = 7'h06;
            else if (blank_lz && i > 0 && m < p) r[7*i +: 7] = 7'h7F;
            else                               r[7*i +: 7] = seg_of((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic set_load(input int sel, input int val, input logic ld);
        if (sel == 0) begin
            value_a = val[8:0];
            load_a  = ld;
        end else begin
            value_b = val[11:0];
            load_b  = ld;
        end
    endtask

    // Load a value and wait for the conversion to finish; optionally pulse a second load mid-conversion
    task automatic applyStimulus(input int sel, input int val, input int glitch_at, input int glitch_val,
                                 output int busy_cycles);
        @(negedge clk);
        set_load(sel, val, 1'b1);
        @(negedge clk);
        set_load(sel, val, 1'b0);
        busy_cycles = 0;
        while (get_busy(sel) && busy_cycles < 100) begin
            if (busy_cycles == glitch_at) set_load(sel, glitch_val, 1'b1);
            else                          set_load(sel, glitch_val, 1'b0);
            busy_cycles++;
            @(negedge clk);
        end
        set_load(sel, 0, 1'b0);
    endtask

    // Watch one full scan and assemble {d3,d2,d1,d0}
    task automatic capture_display(input int sel, output logic [27:0] glyphs, output logic onehot_ok);
        logic [3:0] a;
        glyphs    = 'x;
        onehot_ok = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 4 * REFRESH; n++) begin
            a = get_an(sel);
            case (a)
                4'hE:    glyphs[0  +: 7] = get_seg(sel);
                4'hD:    glyphs[7  +: 7] = get_seg(sel);
                4'hB:    glyphs[14 +: 7] = get_seg(sel);
                4'h7:    glyphs[21 +: 7] = get_seg(sel);
                default: onehot_ok = 1'b0;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic run_vector(input string name, input int sel, input int val, input int glitch_at,
                              input int glitch_val, input logic [27:0] exp_glyphs, input logic exp_ovf);
        int          bc;
        logic [27:0] g;
        logic        oh;
        applyStimulus(sel, val, glitch_at, glitch_val, bc);
        checkOutput({name, " busy_cycles"}, bc, (sel == 0) ? 10 : 13);
        checkOutput({name, " ovf"}, {31'd0, get_ovf(sel)}, {31'd0, exp_ovf});
        capture_display(sel, g, oh);
        checkOutput({name, " glyphs"}, {4'd0, g}, {4'd0, exp_glyphs});
        checkOutput({name, " one_an_low"}, {31'd0, oh}, 32'd1);
    endtask

    initial begin
        int          bc;
        int          sel, val;
        logic [27:0] g;
        logic        oh;

        vecs[0] = '{0, -256, {7'h3F, 7'h24, 7'h12, 7'h02}, 1'b0};
        vecs[1] = '{0,    5, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0};
        vecs[2] = '{1,    5, {7'h7F, 7'h40, 7'h40, 7'h12}, 1'b0};
        vecs[3] = '{0,    0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[4] = '{0,   -1, {7'h3F, 7'h7F, 7'h7F, 7'h79}, 1'b0};
        vecs[5] = '{1, 1500, {7'h7F, 7'h06, 7'h06, 7'h06}, 1'b1};
        vecs[6] = '{1,  999, {7'h7F, 7'h10, 7'h10, 7'h10}, 1'b0};
        vecs[7] = '{1, -2048, {7'h7F, 7'h06, 7'h06, 7'h06}, 1'b1};
        vecs[8] = '{1,  -42, {7'h3F, 7'h40, 7'h19, 7'h24}, 1'b0};

        rst_n   = 1'b0;
        value_a = '0;
        load_a  = 1'b0;
        value_b = '0;
        load_b  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy_a}, 32'd0);
        checkOutput("reset ovf", {31'd0, ovf_a}, 32'd0);
        checkOutput("reset an", {28'd0, an_a}, 32'hF);
        checkOutput("reset sseg", {25'd0, sseg_a}, 32'h7F);

        // Scan order after reset release, blank before any commit
        rst_n = 1'b1;
        for (int n = 0; n < 4 * REFRESH + 1; n++) begin
            @(negedge clk);
            checkOutput("scan an", {28'd0, an_a}, {28'd0, ~(4'b0001 << ((n / REFRESH) % 4))});
            checkOutput("scan blank sseg", {25'd0, sseg_a}, 32'h7F);
        end

        for (int i = 0; i < 9; i++)
            run_vector($sformatf("table[%0d]", i), vecs[i].sel, vecs[i].val, -1, 0, vecs[i].glyphs, vecs[i].ovf);

        // A load during conversion must be ignored
        run_vector("load_while_busy", 0, 123, 2, -7, {7'h7F, 7'h79, 7'h24, 7'h30}, 1'b0);

        for (int r = 0; r < 20; r++) begin
            sel = int'($urandom_range(0, 1));
            if (sel == 0) val = int'($urandom_range(0, 511)) - 256;
            else          val = int'($urandom_range(0, 4095)) - 2048;
            run_vector($sformatf("random[%0d] val=%0d", r, val), sel, val, -1, 0,
                       model_glyphs(val, sel == 0), model_ovf(val));
        end

        // Reset in the middle of a conversion aborts it with no commit
        @(negedge clk);
        set_load(0, 77, 1'b1);
        @(negedge clk);
        set_load(0, 77, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("midconv busy before reset", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midconv reset busy", {31'd0, busy_a}, 32'd0);
        checkOutput("midconv reset an", {28'd0, an_a}, 32'hF);
        checkOutput("midconv reset sseg", {25'd0, sseg_a}, 32'h7F);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midconv no commit busy", {31'd0, busy_a}, 32'd0);
        checkOutput("midconv no commit ovf", {31'd0, ovf_a}, 32'd0);
        capture_display(0, g, oh);
        checkOutput("midconv no commit glyphs", {4'd0, g}, {4'd0, {4{7'h7F}}});
        checkOutput("midconv one_an_low", {31'd0, oh}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
